calc_initiator: RTL and testbench

CALC_INITIATOR -- requirements
Module: calc_initiator

---
 rtl/calc_initiator_pkg.sv | 7 +
 rtl/calc_initiator_timeout_counter.sv | 19 +
 rtl/calc_initiator.sv | 90 +++++++++
 tb/tb_calc_initiator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/calc_initiator_pkg.sv
// calc_initiator_pkg: shared state encoding, calculator op codes and default abort limit
package calc_initiator_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, RELEASE} state_t;
  typedef enum logic [2:0] {OP_SUMA, OP_RESTA, OP_MULTIPLICACION, OP_DIVISION, OP_POTENCIA} op_t;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_OP_MAX = int'(OP_POTENCIA);
endpackage

// File: rtl/calc_initiator_timeout_counter.sv
// timeout_counter: counts enabled cycles from a clear, flags the last allowed cycle
module timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign tc = cnt == LAST;
endmodule

// File: rtl/calc_initiator.sv
// calc_initiator: hands one request at a time to a level-handshake calculator and returns its response
module calc_initiator
  import calc_initiator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int OP_MAX = DEF_OP_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] datoA,
  output logic [WIDTH-1:0] datoB,
  output logic [2:0]       operacion,
  output logic             start,
  input  logic [WIDTH-1:0] resultado,
  input  logic             ready,
  input  logic             error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_resultado,
  output logic             rsp_error,
  output logic             rsp_timeout
);
  localparam logic [2:0] OP_LIM = 3'(OP_MAX);
  state_t state;
  logic tc;
  timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clear(state != ISSUE),
    .enable(state == ISSUE),
    .tc(tc)
  );
  assign req_ready = state == IDLE;
  assign start = state == ISSUE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      datoA <= '0;
      datoB <= '0;
      operacion <= '0;
      rsp_valid <= 1'b0;
      rsp_resultado <= '0;
      rsp_error <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (req_valid && req_op <= OP_LIM) begin
            datoA <= req_a;
            datoB <= req_b;
            operacion <= req_op;
            state <= ISSUE;
          end else if (req_valid) begin
            rsp_resultado <= '0;
            rsp_error <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        // ready outranks an expiring counter in the same cycle
        ISSUE:
          if (ready) begin
            rsp_resultado <= resultado;
            rsp_error <= error;
            rsp_timeout <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end else if (tc) begin
            rsp_resultado <= '0;
            rsp_error <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= RELEASE;
          end
        default:
          if (!ready) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_calc_initiator.sv
// tb_calc_initiator: randomized transactions against a transaction-level model of the initiator
module tb_calc_initiator;
  localparam int TO = 8;
  logic clk = 0, reset, req_valid, req_ready, start, ready, error, rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] req_a, req_b, datoA, datoB, resultado, rsp_resultado;
  logic [2:0] req_op, operacion;
  int tests = 0, fails = 0, starts = 0;
  int cal_lat = 1, cal_sticky = 0;
  bit cal_tog = 0, cal_err = 0;
  logic [31:0] cal_res = 0;
  logic [31:0] exp_a = 0, exp_b = 0, exp_res = 0;
  logic [2:0] exp_op = 0;
  logic exp_err = 0, exp_to = 0;
  int last_w, last_starts, last_k;
  logic [31:0] last_res;
  logic last_err, last_to;

  calc_initiator #(.WIDTH(32), .TIMEOUT_CYCLES(TO), .OP_MAX(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .datoA(datoA), .datoB(datoB), .operacion(operacion), .start(start),
    .resultado(resultado), .ready(ready), .error(error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resultado(rsp_resultado), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // calculator: ready in the cal_lat-th start cycle, optionally lingering (or toggling) afterwards
  initial begin
    int n = 0, sl = 0;
    bit act = 0;
    ready = 0; error = 0; resultado = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n = 0; act = 0; ready = 0;
      end else if (start) begin
        n++; starts++;
        act = n >= cal_lat;
        ready = act;
        resultado = cal_res; error = cal_err; sl = cal_sticky;
      end else begin
        n = 0;
        if (act && sl > 0) begin
          sl--;
          ready = cal_tog ? ~ready : 1'b1;
          if (cal_tog) resultado = $urandom;
        end else begin
          act = 0; ready = 0;
        end
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    if (start) begin
      chk("datoA", datoA, exp_a);
      chk("datoB", datoB, exp_b);
      chk("operacion", {29'd0, operacion}, {29'd0, exp_op});
      chk("req_ready_busy", {31'd0, req_ready}, 0);
    end
    if (rsp_valid) begin
      chk("rsp_resultado", rsp_resultado, exp_res);
      chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
      chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
      chk("req_ready_resp", {31'd0, req_ready}, 0);
    end
  end

  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int lat,
                     input logic [31:0] res, input bit err, input int sticky, input int bp, input bit tog);
    bit legal, tout;
    int m, s_eff, w, c, s0, kexp;
    legal = op <= 4;
    tout = legal && lat > TO;
    m = !legal ? 0 : (tout ? TO : lat);
    s_eff = (legal && !tout) ? sticky : 0;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk("req_ready_idle", {31'd0, req_ready}, 1);
    exp_a = a; exp_b = b; exp_op = op;
    exp_res = (legal && !tout) ? res : 32'd0;
    exp_err = !legal || tout || err;
    exp_to = tout;
    cal_lat = lat; cal_res = res; cal_err = err; cal_sticky = sticky; cal_tog = tog;
    s0 = starts;
    req_valid = 1; req_a = a; req_b = b; req_op = op;
    @(negedge clk);
    req_valid = 0; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
    w = 1;
    while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
    chk("rsp_latency", w, m + 1);
    chk("start_cycles", starts - s0, m);
    last_w = w; last_starts = starts - s0;
    last_res = rsp_resultado; last_err = rsp_error; last_to = rsp_timeout;
    repeat (bp) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 0);
    c = bp + 2;
    while (!req_ready && c < 200) begin @(negedge clk); c++; end
    kexp = ((bp + 2 > s_eff + 1) ? bp + 2 : s_eff + 1) + 1;
    chk("req_ready_return", c, kexp);
    last_k = c;
  endtask

  initial begin
    reset = 1; req_valid = 0; rsp_ready = 0; req_a = 0; req_b = 0; req_op = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_start", {31'd0, start}, 0);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_flags", {30'd0, rsp_error, rsp_timeout}, 0);
    chk("rst_datos", datoA | datoB | {29'd0, operacion}, 0);
    chk("rst_rsp_resultado", rsp_resultado, 0);
    @(negedge clk); reset = 0;
    @(negedge clk);
    txn(5, 500, 4, 3, 32'h1234, 0, 0, 0, 0);
    chk("pin_normal_starts", last_starts, 3);
    chk("pin_normal_res", last_res, 32'h1234);
    chk("pin_normal_flags", {30'd0, last_err, last_to}, 0);
    txn(7, 9, 6, 3, 32'hdead, 0, 0, 0, 0);
    chk("pin_illegal_starts", last_starts, 0);
    chk("pin_illegal_latency", last_w, 1);
    chk("pin_illegal_rsp", {last_res[30:0], last_err}, 1);
    txn(1, 2, 0, 40, 32'h55, 0, 0, 0, 0);
    chk("pin_timeout_starts", last_starts, 8);
    chk("pin_timeout_flags", {30'd0, last_err, last_to}, 3);
    txn(3, 4, 1, 2, 32'hbeef, 1, 6, 10, 1);
    chk("pin_backpressure_k", last_k, 13);
    txn(8, 8, 2, 1, 32'h77, 0, 5, 0, 0);
    chk("pin_sticky_k", last_k, 7);
    txn(9, 9, 3, 1, 32'h99, 0, 0, 0, 0);
    chk("pin_min_period_k", last_k, 3);
    txn(2, 2, 2, 8, 32'h88, 0, 0, 1, 0);
    chk("pin_ready_at_limit", {30'd0, last_err, last_to}, 0);
    cal_lat = 50; cal_sticky = 0; cal_tog = 0;
    exp_a = 32'h11; exp_b = 32'h22; exp_op = 3'd1;
    req_valid = 1; req_a = 32'h11; req_b = 32'h22; req_op = 3'd1;
    @(negedge clk); req_valid = 0;
    repeat (3) @(negedge clk);
    chk("pre_reset_start", {31'd0, start}, 1);
    #1 reset = 1;
    #1;
    chk("async_start_drop", {31'd0, start}, 0);
    chk("async_req_ready", {31'd0, req_ready}, 1);
    chk("async_datoA", datoA, 0);
    @(negedge clk);
    chk("async_rsp_valid", {31'd0, rsp_valid}, 0);
    reset = 0;
    txn(5, 6, 2, 2, 32'hcafe, 0, 0, 0, 0);
    chk("pin_after_reset_res", last_res, 32'hcafe);
    for (int i = 0; i < 40; i++)
      txn($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(1, 10), $urandom,
          1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
